issue_sched: RTL and testbench

Dual-issue in-order issue scheduler with a register scoreboard. Each cycle it decides whether the older (slot A) and younger (slot B) decoded instructions leave ID for EX, and tracks destination registers of in-flight long-latency operations (load, mul/div). It also generates the per-lane `num` order tags. WB uses these tags to resolve same-cycle writes to the same register.

---
 rtl/issue_sched_if.sv | 55 +++++
 rtl/issue_sched.sv | 107 ++++++++++
 tb/tb_issue_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_sched_if
//  Description : Decode-to-issue bundle for the dual-issue scheduler. The
//                decoder side (master) presents slot A/B instructions, stall,
//                flush and long-op completions; the scheduler side (slave)
//                returns issue decisions, order tags and scoreboard state.
//  Revision    : 1.0 - initial release
// ============================================================================
interface issue_sched_if #(
    parameter int REG_NUM = 32
);
    logic               a_valid;
    logic [4:0]         a_rs1;
    logic [4:0]         a_rs2;
    logic [4:0]         a_rd;
    logic               a_rs1_en;
    logic               a_rs2_en;
    logic               a_rfwe;
    logic               a_long;
    logic               a_ctrl;
    logic               b_valid;
    logic [4:0]         b_rs1;
    logic [4:0]         b_rs2;
    logic [4:0]         b_rd;
    logic               b_rs1_en;
    logic               b_rs2_en;
    logic               b_rfwe;
    logic               b_long;
    logic               ex_stall;
    logic               flush;
    logic               done_we;
    logic [4:0]         done_rd;
    logic               issue_a;
    logic               issue_b;
    logic               num_a;
    logic               num_b;
    logic [REG_NUM-1:0] busy;
    logic [2:0]         long_cnt;

    modport master (
        output a_valid, a_rs1, a_rs2, a_rd, a_rs1_en, a_rs2_en, a_rfwe, a_long, a_ctrl,
        output b_valid, b_rs1, b_rs2, b_rd, b_rs1_en, b_rs2_en, b_rfwe, b_long,
        output ex_stall, flush, done_we, done_rd,
        input  issue_a, issue_b, num_a, num_b, busy, long_cnt
    );

    modport slave (
        input  a_valid, a_rs1, a_rs2, a_rd, a_rs1_en, a_rs2_en, a_rfwe, a_long, a_ctrl,
        input  b_valid, b_rs1, b_rs2, b_rd, b_rs1_en, b_rs2_en, b_rfwe, b_long,
        input  ex_stall, flush, done_we, done_rd,
        output issue_a, issue_b, num_a, num_b, busy, long_cnt
    );
endinterface
`default_nettype wire

// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : issue_sched
//  Description : Dual-issue in-order issue scheduler. Decides each cycle
//                whether slot A (older) and slot B (younger) leave ID, keeps
//                a busy scoreboard for long-latency destinations, bounds the
//                number of long ops in flight and produces WB order tags.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_sched #(
    parameter int MAX_LONG = 2,
    parameter int REG_NUM  = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    issue_sched_if.slave sched
);

    localparam logic [2:0] c_max_long = 3'(MAX_LONG);

    logic [REG_NUM-1:0] r_busy;
    logic [2:0]         r_long_cnt;

    logic [31:0]        w_sb;
    logic [31:0]        w_busy_nxt;
    logic               w_hz_a;
    logic               w_hz_b;
    logic               w_pair_dep;
    logic               w_issue_a;
    logic               w_issue_b;
    logic               w_inc_a;
    logic               w_inc_b;
    logic [2:0]         w_cnt_after_a;
    logic [2:0]         w_cnt_sum;
    logic [2:0]         w_cnt_nxt;

    // Widen the scoreboard to the full 5-bit address space so any register index is safe.
    always_comb begin
        w_sb              = '0;
        w_sb[REG_NUM-1:0] = r_busy;
    end

    assign w_hz_a = (sched.a_rs1_en && w_sb[sched.a_rs1])
                  | (sched.a_rs2_en && w_sb[sched.a_rs2])
                  | (sched.a_rfwe && (sched.a_rd != 5'd0) && w_sb[sched.a_rd])
                  | (sched.a_long && (r_long_cnt >= c_max_long));

    assign w_issue_a = rst_n && sched.a_valid && !w_hz_a && !sched.ex_stall && !sched.flush;

    // B sees the credit count as if A's long op (if any) has already been taken.
    assign w_cnt_after_a = r_long_cnt + {2'b00, w_issue_a & sched.a_long};

    assign w_hz_b = (sched.b_rs1_en && w_sb[sched.b_rs1])
                  | (sched.b_rs2_en && w_sb[sched.b_rs2])
                  | (sched.b_rfwe && (sched.b_rd != 5'd0) && w_sb[sched.b_rd])
                  | (sched.b_long && (w_cnt_after_a >= c_max_long));

    assign w_pair_dep = sched.a_rfwe && (sched.a_rd != 5'd0) &&
                        ((sched.b_rs1_en && (sched.b_rs1 == sched.a_rd)) ||
                         (sched.b_rs2_en && (sched.b_rs2 == sched.a_rd)));

    assign w_issue_b = w_issue_a && sched.b_valid && !w_hz_b && !sched.a_ctrl &&
                       !w_pair_dep && !(sched.a_long && sched.b_long);

    assign w_inc_a = w_issue_a & sched.a_long;
    assign w_inc_b = w_issue_b & sched.b_long;

    // Completion clears first, then new long destinations are set so a set always wins.
    always_comb begin
        w_busy_nxt = w_sb;
        if (sched.done_we) begin
            w_busy_nxt[sched.done_rd] = 1'b0;
        end
        if (w_inc_a && sched.a_rfwe) begin
            w_busy_nxt[sched.a_rd] = 1'b1;
        end
        if (w_inc_b && sched.b_rfwe) begin
            w_busy_nxt[sched.b_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Credit count cannot exceed MAX_LONG, so the 3-bit sum never wraps; stray completions saturate at 0.
    assign w_cnt_sum = r_long_cnt + {2'b00, w_inc_a} + {2'b00, w_inc_b};
    assign w_cnt_nxt = (sched.done_we && (w_cnt_sum != 3'd0)) ? (w_cnt_sum - 3'd1) : w_cnt_sum;

    // Scoreboard and long-op credit registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_long_cnt <= 3'd0;
        end else begin
            r_busy     <= w_busy_nxt[REG_NUM-1:0];
            r_long_cnt <= w_cnt_nxt;
        end
    end

    // B is always the surviving writer; A yields its tag only when B issues alongside it.
    assign sched.issue_a  = w_issue_a;
    assign sched.issue_b  = w_issue_b;
    assign sched.num_a    = ~w_issue_b;
    assign sched.num_b    = 1'b1;
    assign sched.busy     = r_busy;
    assign sched.long_cnt = r_long_cnt;

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_sched
//  Description : Self-checking bench for issue_sched: directed vector table,
//                hand-written reset sequences and randomized traffic checked
//                against a behavioural scoreboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_sched;

    localparam int MAX_LONG = 2;
    localparam int REG_NUM  = 32;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       rfwe;
        bit       lng;
        bit [4:0] rs1;
        bit       rs1_en;
        bit [4:0] rs2;
        bit       rs2_en;
        bit       ctrl;
    } slot_t;

    typedef struct {
        slot_t     a;
        slot_t     b;
        bit        stall;
        bit        flush;
        bit        dwe;
        bit [4:0]  drd;
        bit        ia;
        bit        ib;
        bit        na;
        int        cnt;
        bit [31:0] busy;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_sched_if #(.REG_NUM(REG_NUM)) bus ();

    issue_sched #(.MAX_LONG(MAX_LONG), .REG_NUM(REG_NUM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sched (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // stimulus of the current cycle
    slot_t    sa, sb;
    bit       s_stall, s_flush, s_dwe;
    bit [4:0] s_drd;

    // reference model state
    bit [31:0] m_busy;
    int        m_cnt;
    int        q_rd[$];
    bit        e_ia, e_ib;

    vec_t tbl[22];
    vec_t vz;

    function automatic slot_t mk(bit v, bit [4:0] rd, bit we, bit lng,
                                 bit [4:0] r1, bit e1, bit [4:0] r2, bit e2, bit ctrl);
        slot_t s;
        s.valid = v; s.rd = rd; s.rfwe = we; s.lng = lng;
        s.rs1 = r1; s.rs1_en = e1; s.rs2 = r2; s.rs2_en = e2; s.ctrl = ctrl;
        return s;
    endfunction

    function automatic vec_t mv(slot_t a, slot_t b, bit st, bit fl, bit dwe, bit [4:0] drd,
                                bit ia, bit ib, bit na, int cnt, bit [31:0] busy);
        vec_t v;
        v.a = a; v.b = b; v.stall = st; v.flush = fl; v.dwe = dwe; v.drd = drd;
        v.ia = ia; v.ib = ib; v.na = na; v.cnt = cnt; v.busy = busy;
        return v;
    endfunction

    function automatic bit blocked(slot_t s, int cnt);
        return (s.rs1_en && m_busy[s.rs1]) || (s.rs2_en && m_busy[s.rs2]) ||
               (s.rfwe && s.rd != 0 && m_busy[s.rd]) || (s.lng && cnt >= MAX_LONG);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive();
        bus.a_valid = sa.valid; bus.a_rd = sa.rd; bus.a_rfwe = sa.rfwe; bus.a_long = sa.lng;
        bus.a_rs1 = sa.rs1; bus.a_rs1_en = sa.rs1_en; bus.a_rs2 = sa.rs2; bus.a_rs2_en = sa.rs2_en;
        bus.a_ctrl = sa.ctrl;
        bus.b_valid = sb.valid; bus.b_rd = sb.rd; bus.b_rfwe = sb.rfwe; bus.b_long = sb.lng;
        bus.b_rs1 = sb.rs1; bus.b_rs1_en = sb.rs1_en; bus.b_rs2 = sb.rs2; bus.b_rs2_en = sb.rs2_en;
        bus.ex_stall = s_stall; bus.flush = s_flush; bus.done_we = s_dwe; bus.done_rd = s_drd;
    endtask

    // One clock: drive, compare mid-cycle, advance the model after the edge.
    task automatic cycle(input bit use_tbl, input vec_t v);
        bit dep;
        int n;
        drive();
        #4;
        dep  = sa.rfwe && sa.rd != 0 &&
               ((sb.rs1_en && sb.rs1 == sa.rd) || (sb.rs2_en && sb.rs2 == sa.rd));
        e_ia = rst_n && sa.valid && !blocked(sa, m_cnt) && !s_stall && !s_flush;
        e_ib = e_ia && sb.valid && !blocked(sb, m_cnt + ((e_ia && sa.lng) ? 1 : 0)) &&
               !sa.ctrl && !dep && !(sa.lng && sb.lng);
        check("issue_a", 32'(bus.issue_a), 32'(e_ia));
        check("issue_b", 32'(bus.issue_b), 32'(e_ib));
        check("num_a", 32'(bus.num_a), e_ib ? 32'd0 : 32'd1);
        check("num_b", 32'(bus.num_b), 32'd1);
        check("busy", bus.busy, m_busy);
        check("long_cnt", 32'(bus.long_cnt), 32'(m_cnt));
        if (use_tbl) begin
            check("tbl_issue_a", 32'(bus.issue_a), 32'(v.ia));
            check("tbl_issue_b", 32'(bus.issue_b), 32'(v.ib));
            check("tbl_num_a", 32'(bus.num_a), 32'(v.na));
            check("tbl_long_cnt", 32'(bus.long_cnt), 32'(v.cnt));
            check("tbl_busy", bus.busy, v.busy);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_busy = '0;
            m_cnt  = 0;
            q_rd.delete();
        end else begin
            n = 0;
            if (s_dwe) m_busy[s_drd] = 1'b0;
            if (e_ia && sa.lng) begin
                n++;
                if (sa.rfwe && sa.rd != 0) m_busy[sa.rd] = 1'b1;
                q_rd.push_back((sa.rfwe && sa.rd != 0) ? int'(sa.rd) : 0);
            end
            if (e_ib && sb.lng) begin
                n++;
                if (sb.rfwe && sb.rd != 0) m_busy[sb.rd] = 1'b1;
                q_rd.push_back((sb.rfwe && sb.rd != 0) ? int'(sb.rd) : 0);
            end
            m_busy[0] = 1'b0;
            m_cnt = m_cnt + n;
            if (s_dwe && m_cnt > 0) m_cnt--;
        end
    endtask

    function automatic slot_t rnd_slot();
        return mk($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), ($urandom % 4) != 0,
                  ($urandom % 3) == 0, 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom), ($urandom % 6) == 0);
    endfunction

    initial begin
        slot_t nop, ia_, ib_;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vz  = mv(nop, nop, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        m_busy = '0; m_cnt = 0;
        sa = nop; sb = nop; s_stall = 0; s_flush = 0; s_dwe = 0; s_drd = 0;

        // directed table (starts from an empty scoreboard)
        tbl[0]  = mv(mk(1, 5, 1, 1, 0, 0, 0, 0, 0), nop, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        tbl[1]  = mv(mk(1, 6, 1, 0, 5, 1, 0, 0, 0), nop, 0, 0, 0, 0, 0, 0, 1, 1, 32'h20);
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mv(mk(1, 6, 1, 0, 5, 1, 0, 0, 0), nop, 0, 0, 1, 5, 0, 0, 1, 1, 32'h20);
        tbl[5]  = mv(mk(1, 6, 1, 0, 5, 1, 0, 0, 0), nop, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        tbl[6]  = mv(mk(1, 3, 1, 0, 0, 0, 0, 0, 0), mk(1, 4, 1, 0, 3, 1, 0, 0, 0), 0, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        tbl[7]  = mv(mk(1, 4, 1, 0, 3, 1, 0, 0, 0), nop, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        tbl[8]  = mv(mk(1, 7, 1, 0, 0, 0, 0, 0, 0), mk(1, 7, 1, 0, 1, 1, 0, 0, 0), 0, 0, 0, 0, 1, 1, 0, 0, 32'h0);
        tbl[9]  = mv(mk(1, 10, 1, 1, 0, 0, 0, 0, 0), mk(1, 11, 1, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 1, 0, 32'h0);
        tbl[10] = mv(mk(1, 11, 1, 1, 0, 0, 0, 0, 0), mk(1, 20, 1, 0, 10, 1, 0, 0, 0), 0, 0, 0, 0, 1, 0, 1, 1, 32'h400);
        tbl[11] = mv(mk(1, 12, 1, 1, 0, 0, 0, 0, 0), nop, 0, 0, 0, 0, 0, 0, 1, 2, 32'hC00);
        tbl[12] = mv(mk(1, 12, 1, 1, 0, 0, 0, 0, 0), nop, 0, 0, 1, 10, 0, 0, 1, 2, 32'hC00);
        tbl[13] = mv(mk(1, 12, 1, 1, 0, 0, 0, 0, 0), nop, 0, 0, 1, 11, 1, 0, 1, 1, 32'h800);
        tbl[14] = mv(mk(1, 0, 1, 1, 0, 0, 0, 0, 0), nop, 0, 0, 0, 0, 1, 0, 1, 1, 32'h1000);
        tbl[15] = mv(mk(1, 1, 1, 0, 0, 0, 0, 0, 1), mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 1, 2, 32'h1000);
        tbl[16] = mv(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 1, 0, 1, 12, 0, 0, 1, 2, 32'h1000);
        tbl[17] = mv(mk(1, 14, 1, 1, 0, 0, 0, 0, 0), mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0, 1, 1, 32'h0);
        tbl[18] = mv(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1, 1, 0, 1, 32'h0);
        tbl[19] = mv(nop, nop, 0, 0, 1, 0, 0, 0, 1, 1, 32'h0);
        tbl[20] = mv(nop, nop, 0, 0, 1, 3, 0, 0, 1, 0, 32'h0);
        tbl[21] = mv(nop, nop, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);

        drive();
        @(posedge clk);
        #1;

        // reset held for two cycles with an independent pair presented
        ia_ = mk(1, 1, 1, 0, 2, 1, 0, 0, 0);
        ib_ = mk(1, 3, 1, 0, 4, 1, 0, 0, 0);
        rst_n = 1'b0; sa = ia_; sb = ib_;
        for (int i = 0; i < 2; i++) begin
            cycle(0, vz);
            check("rst_issue_a", 32'(bus.issue_a), 32'd0);
            check("rst_num_a", 32'(bus.num_a), 32'd1);
        end
        rst_n = 1'b1;
        drive();
        #4;
        check("post_rst_issue_b", 32'(bus.issue_b), 32'd1);
        check("post_rst_num_a", 32'(bus.num_a), 32'd0);
        #1;
        cycle(0, vz);

        for (int i = 0; i < 22; i++) begin
            sa = tbl[i].a; sb = tbl[i].b; s_stall = tbl[i].stall; s_flush = tbl[i].flush;
            s_dwe = tbl[i].dwe; s_drd = tbl[i].drd;
            cycle(1, tbl[i]);
        end

        // reset in the middle of two outstanding long ops; late completion is ignored
        s_stall = 0; s_flush = 0; s_dwe = 0; sb = nop;
        sa = mk(1, 9, 1, 1, 0, 0, 0, 0, 0);  cycle(0, vz);
        sa = mk(1, 13, 1, 1, 0, 0, 0, 0, 0); cycle(0, vz);
        sa = nop; rst_n = 1'b0; cycle(0, vz);
        rst_n = 1'b1; s_dwe = 1; s_drd = 9; cycle(0, vz);
        s_dwe = 0;
        drive();
        #4;
        check("late_done_cnt", 32'(bus.long_cnt), 32'd0);
        check("late_done_busy", bus.busy, 32'd0);
        #1;
        cycle(0, vz);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            sa = rnd_slot(); sb = rnd_slot();
            s_stall = ($urandom % 8) == 0;
            s_flush = ($urandom % 10) == 0;
            s_dwe = 0;
            s_drd = 5'($urandom_range(0, 7));
            if (q_rd.size() > 0 && ($urandom % 2) == 1) begin
                int idx;
                idx = $urandom_range(0, q_rd.size() - 1);
                s_dwe = 1;
                s_drd = 5'(q_rd[idx]);
                q_rd.delete(idx);
            end else if (q_rd.size() == 0 && ($urandom % 10) == 0) begin
                s_dwe = 1;
            end
            rst_n = ($urandom % 60) != 0;
            cycle(0, vz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
